// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD seven-segment display: converter states,
// digit count, segment glyphs and the double-dabble nibble correction.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONV,
    LATCH
  } convState_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high glyphs, bit0 = segment a through bit6 = segment g
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] segPattern(input logic [3:0] digit);
    logic [6:0] glyph;
    glyph = SEG_BLANK;
    if (digit <= 4'd9) glyph = SEG_TABLE[digit];
    return glyph;
  endfunction

  function automatic logic [11:0] dabbleAdjust(input logic [11:0] bcd);
    logic [11:0] result;
    result = bcd;
    for (int n = 0; n < 3; n++) begin
      if (result[4*n +: 4] >= 4'd5) result[4*n +: 4] = result[4*n +: 4] + 4'd3;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_bcd_display_if.sv
// Display-side bundle: the binary count coming in and the segment/anode drive going out.
interface seg7_bcd_display_if;

  logic [7:0] VALUE;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  modport master (output VALUE, input SEG, DP, AN);
  modport slave  (input VALUE, output SEG, DP, AN);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter using one double-dabble step per cycle.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_i,
  input  logic [7:0] value_i,
  output logic       ready_o,
  output logic       done_o,
  output bcd_t       bcd_o
);

  convState_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] adjusted;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  // Next state; the eighth CONV step (iter 7) hands over to LATCH
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    adjusted = dabbleAdjust(acc_q);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = value_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = '0;
        iter_d  = '0;
        state_d = CONV;
      end
      CONV: begin
        acc_d   = (adjusted << 1) | {11'd0, shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = (state_q == LATCH);
    bcd_o   = bcd_t'(acc_q);
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// Multiplexed decimal display for an 8-bit count: reconverts whenever the count changes
// and scans four digits, blanking leading zeros and the unused leftmost digit.
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  seg7_bcd_display_if.slave disp_io
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [7:0]            lastValue_q;
  bcd_t                  disp_q;
  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      digit_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  convReady;
  logic                  convDone;
  bcd_t                  convBcd;
  logic                  startConv;
  logic                  tick;
  logic [IDX_W-1:0]      nextDigit;
  logic [6:0]            segHigh;
  logic [NUM_DIGITS-1:0] anHigh;

  bin2bcd_seq uConv (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (startConv),
    .value_i (disp_io.VALUE),
    .ready_o (convReady),
    .done_o  (convDone),
    .bcd_o   (convBcd)
  );

  assign startConv = convReady && (disp_io.VALUE != lastValue_q);
  assign tick      = (div_q == DIV_W'(DIV - 1));

  // Glyph for the digit about to be enabled; tens stays lit under a nonzero hundreds
  always_comb begin
    nextDigit = digit_q + 1'b1;
    segHigh   = SEG_BLANK;
    case (nextDigit)
      2'd0: segHigh = segPattern(disp_q.ones);
      2'd1: if (disp_q.hundreds != 4'd0 || disp_q.tens != 4'd0) segHigh = segPattern(disp_q.tens);
      2'd2: if (disp_q.hundreds != 4'd0) segHigh = segPattern(disp_q.hundreds);
      default: segHigh = SEG_BLANK;
    endcase
    anHigh = NUM_DIGITS'(1) << nextDigit;
  end

  // Conversion bookkeeping, scan divider and registered pin drive
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lastValue_q <= '0;
      disp_q      <= '0;
      div_q       <= '0;
      digit_q     <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
    end else begin
      if (startConv) lastValue_q <= disp_io.VALUE;
      if (convDone) disp_q <= convBcd;
      div_q <= tick ? '0 : div_q + 1'b1;
      dp_q  <= DP_OFF;
      if (tick) begin
        digit_q <= nextDigit;
        seg_q   <= SEG_ACTIVE_LOW ? ~segHigh : segHigh;
        an_q    <= AN_ACTIVE_LOW ? ~anHigh : anHigh;
      end
    end
  end

  assign disp_io.SEG = seg_q;
  assign disp_io.DP  = dp_q;
  assign disp_io.AN  = an_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Randomized scoreboard bench for seg7_bcd_display with DIV=4 and active-low drive;
// a decimal-arithmetic model predicts each scan slot and the latched display value.
module tb_seg7_bcd_display;
  import seg7_pkg::*;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scanItem_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  seg7_bcd_display_if bus ();

  seg7_bcd_display #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (250),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .disp_io (bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0] digitGlyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int checks = 0;
  int errors = 0;

  scanItem_t expQ [$];
  int        edgeCount  = 0;
  bit        busy       = 1'b0;
  int        doneEdge   = 0;
  int        lastSeen   = 0;
  int        convValue  = 0;
  int        shownValue = 0;
  logic [3:0] prevAn    = 4'hF;
  logic [6:0] prevSeg   = 7'h7F;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic scanItem_t expectedScan(input int v, input int slot);
    scanItem_t  item;
    logic [6:0] glyph;
    logic [3:0] anHigh;
    glyph = 7'h00;
    case (slot)
      0: glyph = digitGlyph[v % 10];
      1: if (v >= 10) glyph = digitGlyph[(v / 10) % 10];
      2: if (v >= 100) glyph = digitGlyph[v / 100];
      default: glyph = 7'h00;
    endcase
    anHigh   = 4'b0001 << slot;
    item.an  = ~anHigh;
    item.seg = ~glyph;
    return item;
  endfunction

  function automatic logic [11:0] toBcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Reference model: a scan slot every 4 edges, and a conversion that lands 10 edges
  // after it starts, with the converter deaf to the input until it has finished
  always @(posedge CLK) begin
    if (RST) begin
      edgeCount  = 0;
      busy       = 1'b0;
      lastSeen   = 0;
      shownValue = 0;
      expQ.delete();
    end else begin
      edgeCount++;
      if (edgeCount % 4 == 0) expQ.push_back(expectedScan(shownValue, (edgeCount / 4) % 4));
      if (busy && edgeCount == doneEdge) begin
        shownValue = convValue;
        busy       = 1'b0;
      end else if (!busy && int'(bus.VALUE) != lastSeen) begin
        lastSeen  = int'(bus.VALUE);
        convValue = int'(bus.VALUE);
        busy      = 1'b1;
        doneEdge  = edgeCount + 10;
      end
    end
  end

  // Monitor: pops a predicted scan slot whenever one is due, otherwise the pins must hold
  always @(negedge CLK) begin
    scanItem_t item;
    if (RST) begin
      checkOutput("resetAn", 32'(bus.AN), 32'h0000000F);
      checkOutput("resetSeg", 32'(bus.SEG), 32'h0000007F);
      checkOutput("resetDp", 32'(bus.DP), 32'd1);
      checkOutput("resetDisp", 32'(dut.disp_q), 32'd0);
      checkOutput("resetFsmIdle", 32'(dut.uConv.state_q), 32'(IDLE));
    end else begin
      checkOutput("dispReg", 32'(dut.disp_q), 32'(toBcd(shownValue)));
      checkOutput("dp", 32'(bus.DP), 32'd1);
      if (expQ.size() > 0) begin
        item = expQ.pop_front();
        checkOutput("scanAn", 32'(bus.AN), 32'(item.an));
        checkOutput("scanSeg", 32'(bus.SEG), 32'(item.seg));
      end else begin
        checkOutput("anHold", 32'(bus.AN), 32'(prevAn));
        checkOutput("segHold", 32'(bus.SEG), 32'(prevSeg));
      end
    end
    prevAn  = bus.AN;
    prevSeg = bus.SEG;
  end

  // Called two time units after a rising edge; leaves the bench at the same phase
  task automatic applyStimulus(input logic [7:0] value, input int holdCycles);
    bus.VALUE = value;
    repeat (holdCycles) @(posedge CLK);
    #2;
  endtask

  task automatic pulseReset(input int cycles);
    RST = 1'b1;
    repeat (cycles) @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    bus.VALUE = 8'd0;
    #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;

    applyStimulus(8'd0, 40);
    applyStimulus(8'd255, 40);
    applyStimulus(8'd7, 40);
    applyStimulus(8'd100, 40);
    applyStimulus(8'd5, 4);
    applyStimulus(8'd9, 40);
    applyStimulus(8'd200, 5);
    pulseReset(3);
    applyStimulus(8'd200, 40);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(1, 25)));
      if (i == 20) pulseReset(2);
    end
    applyStimulus(bus.VALUE, 40);

    @(negedge CLK);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
